// File: rtl/wb_commit_pkg.sv
// Shared definitions for the write-back/commit stage.
//   - ExcCode values written into Cause.ExcCode
//   - CP0 register numbers decoded by the MTC0 write path and the read mux
//   - Status/Cause bit positions and MTC0 writable-bit masks
//   - bc_inst encodings for syscall/break
package wb_commit_pkg;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // CP0 register numbers (select 0 only)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Status bit positions
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_IM_LSB = 8;

  // Cause bit positions
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_HW_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  // Bits that MTC0 is allowed to change
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // bc_inst encodings
  localparam logic [1:0] BC_SYSCALL = 2'b01;
  localparam logic [1:0] BC_BREAK   = 2'b10;

  // Address-error exceptions are the only ones that capture BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/wb_commit_cp0_regs.sv
// CP0 register storage: BadVAddr, Count, Compare, Status, Cause, EPC,
// the half-rate Count timer and the combinational read mux.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   hw_int_i            external interrupt levels sampled into Cause.IP[15:10]
//   mtc0_wen_i ..       MTC0 write port (already suppressed on exception/ERET)
//   exc_commit_i ..     exception update: code, EPC candidate, BD, faulting addr
//   eret_commit_i       clear Status.EXL
//   cp0_rnum_i/rsel_i   read port, cp0_rdata_o returns current register state
//   int_req_o           enabled interrupt pending
//   epc_o               current EPC (ERET target)
module cp0_regs
  import wb_commit_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int_i,
  input  logic        mtc0_wen_i,
  input  logic [4:0]  cp0_num_i,
  input  logic [2:0]  cp0_sel_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        exc_commit_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] epc_value_i,
  input  logic        bd_value_i,
  input  logic [31:0] bad_address_i,
  input  logic        eret_commit_i,
  input  logic [4:0]  cp0_rnum_i,
  input  logic [2:0]  cp0_rsel_i,
  output logic [31:0] cp0_rdata_o,
  output logic        int_req_o,
  output logic [31:0] epc_o
);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        tick_q, tick_d;

  logic wr_ok;
  logic timer_hit;

  assign wr_ok     = mtc0_wen_i && (cp0_sel_i == 3'd0);
  assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q + {31'd0, tick_q};
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    tick_d     = ~tick_q;

    // IP7 carries the registered timer flag, so it follows TI by one cycle.
    cause_d[CAUSE_HW_LSB +: 6] = {hw_int_i[5] | cause_q[CAUSE_TI], hw_int_i[4:0]};
    if (timer_hit) begin
      cause_d[CAUSE_TI] = 1'b1;
    end

    // Later assignments override the timer increment / TI set.
    if (wr_ok) begin
      case (cp0_num_i)
        CP0_COUNT:   count_d = cp0_wdata_i;
        CP0_COMPARE: begin
          compare_d          = cp0_wdata_i;
          cause_d[CAUSE_TI]  = 1'b0;
        end
        CP0_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (cp0_wdata_i & STATUS_WMASK);
        CP0_CAUSE:   cause_d[CAUSE_IP_LSB +: 2] = cp0_wdata_i[CAUSE_IP_LSB +: 2];
        CP0_EPC:     epc_d = cp0_wdata_i;
        default:     ;
      endcase
    end

    if (exc_commit_i) begin
      cause_d[CAUSE_EXC_LSB +: 5] = exc_code_i;
      status_d[STATUS_EXL]        = 1'b1;
      // A nested exception keeps the original return point.
      if (!status_q[STATUS_EXL]) begin
        epc_d             = epc_value_i;
        cause_d[CAUSE_BD] = bd_value_i;
      end
      if (is_addr_exc(exc_code_i)) begin
        badvaddr_d = bad_address_i;
      end
    end else if (eret_commit_i) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      tick_q     <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    cp0_rdata_o = 32'd0;
    if (cp0_rsel_i == 3'd0) begin
      case (cp0_rnum_i)
        CP0_BADVADDR: cp0_rdata_o = badvaddr_q;
        CP0_COUNT:    cp0_rdata_o = count_q;
        CP0_COMPARE:  cp0_rdata_o = compare_q;
        CP0_STATUS:   cp0_rdata_o = status_q;
        CP0_CAUSE:    cp0_rdata_o = cause_q;
        CP0_EPC:      cp0_rdata_o = epc_q;
        default:      cp0_rdata_o = 32'd0;
      endcase
    end
  end

  assign int_req_o = status_q[STATUS_IE] && !status_q[STATUS_EXL] &&
                     (|(cause_q[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8]));
  assign epc_o     = epc_q;

endmodule

// File: rtl/wb_commit.sv
// Write-back / commit stage.
// Consumes the registered memory-stage outputs, drives the register-file
// write port, arbitrates exceptions, and issues a one-cycle flush with a
// redirect PC on an exception or ERET. CP0 state lives in cp0_regs.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   pc_in, wb_data, reg_wen, reg_num instruction in WB and its GPR result
//   cp0_wen/num/sel/wdata            MTC0 request
//   overflow, eret, bad_inst, bc_inst,
//   addr_err_read/write, bad_address,
//   in_delay_slot                    exception sources / context
//   hw_int                           external interrupt levels
//   rf_wen/waddr/wdata               register-file write port
//   cp0_rnum/rsel -> cp0_rdata       CP0 read port for EXE
//   flush_out, redirect_pc           front-end flush and new fetch PC
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] wb_data,
  input  logic        reg_wen,
  input  logic [4:0]  reg_num,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_num,
  input  logic [2:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  input  logic        overflow,
  input  logic        eret,
  input  logic        bad_inst,
  input  logic [1:0]  bc_inst,
  input  logic        addr_err_read,
  input  logic        addr_err_write,
  input  logic [31:0] bad_address,
  input  logic        in_delay_slot,
  input  logic [5:0]  hw_int,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  cp0_rnum,
  input  logic [2:0]  cp0_rsel,
  output logic [31:0] cp0_rdata,
  output logic        flush_out,
  output logic [31:0] redirect_pc
);

  logic        int_req;
  logic        exc;
  logic [4:0]  exc_code;
  logic [31:0] epc_cur;
  logic [31:0] epc_value;
  logic        eret_commit;
  logic        mtc0_wen;

  // Fixed-priority arbiter, highest priority first.
  always_comb begin
    exc      = 1'b1;
    exc_code = EXC_INT;
    if (int_req)                    exc_code = EXC_INT;
    else if (bad_inst)              exc_code = EXC_RI;
    else if (overflow)              exc_code = EXC_OV;
    else if (bc_inst == BC_SYSCALL) exc_code = EXC_SYS;
    else if (bc_inst == BC_BREAK)   exc_code = EXC_BP;
    else if (addr_err_read)         exc_code = EXC_ADEL;
    else if (addr_err_write)        exc_code = EXC_ADES;
    else                            exc      = 1'b0;
  end

  assign eret_commit = eret && !exc;
  // An exception or ERET squashes the instruction's MTC0.
  assign mtc0_wen    = cp0_wen && !exc && !eret;
  assign epc_value   = in_delay_slot ? (pc_in - 32'd4) : pc_in;

  // Outputs are held quiet while reset is asserted, regardless of inputs.
  assign flush_out   = !rst && (exc || eret);
  assign redirect_pc = rst         ? 32'd0 :
                       exc         ? EXC_VECTOR :
                       eret_commit ? epc_cur : 32'd0;
  assign rf_wen      = !rst && !exc && !eret && reg_wen && (reg_num != 5'd0);
  assign rf_waddr    = reg_num;
  assign rf_wdata    = wb_data;

  cp0_regs #(
    .STATUS_RST(STATUS_RST)
  ) u_cp0_regs (
    .clk          (clk),
    .rst          (rst),
    .hw_int_i     (hw_int),
    .mtc0_wen_i   (mtc0_wen),
    .cp0_num_i    (cp0_num),
    .cp0_sel_i    (cp0_sel),
    .cp0_wdata_i  (cp0_wdata),
    .exc_commit_i (exc),
    .exc_code_i   (exc_code),
    .epc_value_i  (epc_value),
    .bd_value_i   (in_delay_slot),
    .bad_address_i(bad_address),
    .eret_commit_i(eret_commit),
    .cp0_rnum_i   (cp0_rnum),
    .cp0_rsel_i   (cp0_rsel),
    .cp0_rdata_o  (cp0_rdata),
    .int_req_o    (int_req),
    .epc_o        (epc_cur)
  );

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] wb_data;
  logic        reg_wen;
  logic [4:0]  reg_num;
  logic        cp0_wen;
  logic [4:0]  cp0_num;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic        overflow;
  logic        eret;
  logic        bad_inst;
  logic [1:0]  bc_inst;
  logic        addr_err_read;
  logic        addr_err_write;
  logic [31:0] bad_address;
  logic        in_delay_slot;
  logic [5:0]  hw_int;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  cp0_rnum;
  logic [2:0]  cp0_rsel;
  logic [31:0] cp0_rdata;
  logic        flush_out;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  wb_commit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .wb_data       (wb_data),
    .reg_wen       (reg_wen),
    .reg_num       (reg_num),
    .cp0_wen       (cp0_wen),
    .cp0_num       (cp0_num),
    .cp0_sel       (cp0_sel),
    .cp0_wdata     (cp0_wdata),
    .overflow      (overflow),
    .eret          (eret),
    .bad_inst      (bad_inst),
    .bc_inst       (bc_inst),
    .addr_err_read (addr_err_read),
    .addr_err_write(addr_err_write),
    .bad_address   (bad_address),
    .in_delay_slot (in_delay_slot),
    .hw_int        (hw_int),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .cp0_rnum      (cp0_rnum),
    .cp0_rsel      (cp0_rsel),
    .cp0_rdata     (cp0_rdata),
    .flush_out     (flush_out),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] num, input logic [31:0] exp);
    cp0_rnum = num;
    cp0_rsel = 3'd0;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic idle();
    pc_in = 32'd0; wb_data = 32'd0; reg_wen = 1'b0; reg_num = 5'd0;
    cp0_wen = 1'b0; cp0_num = 5'd0; cp0_sel = 3'd0; cp0_wdata = 32'd0;
    overflow = 1'b0; eret = 1'b0; bad_inst = 1'b0; bc_inst = 2'b00;
    addr_err_read = 1'b0; addr_err_write = 1'b0; bad_address = 32'd0;
    in_delay_slot = 1'b0; hw_int = 6'd0;
  endtask

  task automatic step(input string name);
    $display("step: %s", name);
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
    idle();
    cp0_wen = 1'b1; cp0_num = num; cp0_wdata = data;
  endtask

  initial begin
    rst = 1'b1;
    cp0_rnum = 5'd0; cp0_rsel = 3'd0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    #1;
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_flush", {31'd0, flush_out}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    rd("rst_status", 5'd12, 32'h0040_0000);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_count", 5'd9, 32'd0);
    rd("rst_compare", 5'd11, 32'd0);
    rd("rst_badv", 5'd8, 32'd0);

    // Timer: Compare=4, Status IM7|IE
    mtc0(5'd11, 32'd4);
    step("mtc0 compare=4");                 // E1
    mtc0(5'd12, 32'h0000_8001);
    step("mtc0 status=8001");               // E2
    idle();
    for (int i = 0; i < 6; i++) step("idle"); // E3..E8
    rd("count_at_e8", 5'd9, 32'd4);
    rd("cause_pre_ti", 5'd13, 32'd0);
    step("idle");                           // E9
    rd("cause_ti", 5'd13, 32'h4000_0000);
    chk("no_int_yet", {31'd0, flush_out}, 32'd0);
    step("idle");                           // E10
    rd("cause_ip7", 5'd13, 32'h4000_8000);
    chk("int_flush", {31'd0, flush_out}, 32'd1);
    pc_in = 32'h8000_0100; reg_wen = 1'b1; reg_num = 5'd3; wb_data = 32'hAAAA_5555;
    #1;
    chk("int_redirect", redirect_pc, 32'hBFC0_0380);
    chk("int_rf_wen", {31'd0, rf_wen}, 32'd0);
    step("interrupt taken");                // E11
    idle();
    rd("int_cause", 5'd13, 32'h4000_8000);
    rd("int_epc", 5'd14, 32'h8000_0100);
    rd("int_status", 5'd12, 32'h0040_8003);
    chk("exl_masks_int", {31'd0, flush_out}, 32'd0);
    mtc0(5'd11, 32'h0000_0100);
    step("mtc0 compare clears TI");         // E12
    idle();
    rd("ti_cleared", 5'd13, 32'h0000_8000);
    rd("compare_100", 5'd11, 32'h0000_0100);
    step("idle");                           // E13
    rd("ip7_cleared", 5'd13, 32'd0);
    eret = 1'b1;
    #1;
    chk("eret1_flush", {31'd0, flush_out}, 32'd1);
    chk("eret1_redirect", redirect_pc, 32'h8000_0100);
    step("eret");
    idle();
    rd("eret1_status", 5'd12, 32'h0040_8001);
    mtc0(5'd12, 32'd0);
    step("mtc0 status=0");
    idle();
    rd("status_cleared", 5'd12, 32'h0040_0000);

    // Register-file write port
    reg_wen = 1'b1; reg_num = 5'd5; wb_data = 32'h0000_1234;
    #1;
    chk("rf_wen", {31'd0, rf_wen}, 32'd1);
    chk("rf_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("rf_wdata", rf_wdata, 32'h0000_1234);
    chk("rf_noflush", {31'd0, flush_out}, 32'd0);
    reg_num = 5'd0;
    #1;
    chk("rf_r0", {31'd0, rf_wen}, 32'd0);
    step("rf write");

    // MTC0 visible only after commit
    mtc0(5'd14, 32'h1111_0000);
    rd("epc_no_bypass", 5'd14, 32'h8000_0100);
    step("mtc0 epc");
    idle();
    rd("epc_written", 5'd14, 32'h1111_0000);

    // Non-zero select ignored; BadVAddr read-only
    mtc0(5'd11, 32'h77);
    cp0_sel = 3'd1;
    step("mtc0 compare sel1");
    idle();
    rd("sel1_write_ignored", 5'd11, 32'h0000_0100);
    cp0_rnum = 5'd11; cp0_rsel = 3'd1;
    #1;
    chk("sel1_read_zero", cp0_rdata, 32'd0);
    cp0_rsel = 3'd0;
    mtc0(5'd8, 32'h0000_FFFF);
    step("mtc0 badvaddr");
    idle();
    rd("badv_readonly", 5'd8, 32'd0);

    // Writable-bit masks
    mtc0(5'd13, 32'hFFFF_FFFF);
    step("mtc0 cause all ones");
    idle();
    rd("cause_mask", 5'd13, 32'h0000_0300);
    mtc0(5'd12, 32'hFFFF_FFFF);
    step("mtc0 status all ones");
    idle();
    rd("status_mask", 5'd12, 32'h0040_FF03);
    chk("swint_masked_by_exl", {31'd0, flush_out}, 32'd0);
    mtc0(5'd13, 32'd0);
    step("mtc0 cause=0");
    mtc0(5'd12, 32'd0);
    step("mtc0 status=0");
    idle();
    rd("status_restored", 5'd12, 32'h0040_0000);
    rd("cause_restored", 5'd13, 32'd0);

    // Overflow + syscall in delay slot, MTC0 suppressed
    overflow = 1'b1; bc_inst = 2'b01; pc_in = 32'h8000_1000; in_delay_slot = 1'b1;
    reg_wen = 1'b1; reg_num = 5'd5;
    cp0_wen = 1'b1; cp0_num = 5'd11; cp0_wdata = 32'h55;
    #1;
    chk("ov_flush", {31'd0, flush_out}, 32'd1);
    chk("ov_redirect", redirect_pc, 32'hBFC0_0380);
    chk("ov_rf_wen", {31'd0, rf_wen}, 32'd0);
    step("overflow+syscall");
    idle();
    rd("ov_epc", 5'd14, 32'h8000_0FFC);
    rd("ov_cause", 5'd13, 32'h8000_0030);
    rd("ov_status", 5'd12, 32'h0040_0002);
    rd("ov_mtc0_squashed", 5'd11, 32'h0000_0100);

    // Load address error while EXL=1
    addr_err_read = 1'b1; bad_address = 32'h8000_0003; pc_in = 32'h8000_0200;
    #1;
    chk("adel_flush", {31'd0, flush_out}, 32'd1);
    step("addr_err_read");
    idle();
    rd("adel_badv", 5'd8, 32'h8000_0003);
    rd("adel_cause", 5'd13, 32'h8000_0010);
    rd("adel_epc_kept", 5'd14, 32'h8000_0FFC);
    eret = 1'b1;
    #1;
    chk("eret2_flush", {31'd0, flush_out}, 32'd1);
    chk("eret2_redirect", redirect_pc, 32'h8000_0FFC);
    step("eret");
    idle();
    rd("eret2_status", 5'd12, 32'h0040_0000);

    // Break together with eret: exception wins
    bc_inst = 2'b10; eret = 1'b1; pc_in = 32'h8000_3000;
    #1;
    chk("bp_redirect", redirect_pc, 32'hBFC0_0380);
    step("break+eret");
    idle();
    rd("bp_epc", 5'd14, 32'h8000_3000);
    rd("bp_cause", 5'd13, 32'h0000_0024);
    rd("bp_status", 5'd12, 32'h0040_0002);

    // Nested: bad_inst beats overflow and addr_err_write
    bad_inst = 1'b1; overflow = 1'b1; addr_err_write = 1'b1;
    pc_in = 32'h8000_2000; bad_address = 32'h1234_5678;
    step("bad_inst nested");
    idle();
    rd("ri_epc_kept", 5'd14, 32'h8000_3000);
    rd("ri_cause", 5'd13, 32'h0000_0028);
    rd("ri_badv_kept", 5'd8, 32'h8000_0003);

    addr_err_write = 1'b1; bad_address = 32'h0000_0ABC;
    step("addr_err_write");
    idle();
    rd("ades_cause", 5'd13, 32'h0000_0014);
    rd("ades_badv", 5'd8, 32'h0000_0ABC);
    eret = 1'b1;
    #1;
    chk("eret3_redirect", redirect_pc, 32'h8000_3000);
    step("eret");
    idle();
    rd("eret3_status", 5'd12, 32'h0040_0000);

    // Asynchronous reset mid-cycle
    mtc0(5'd12, 32'h0000_FF01);
    step("mtc0 status=FF01");
    idle();
    rd("pre_rst_status", 5'd12, 32'h0040_FF01);
    overflow = 1'b1;
    #1;
    chk("pre_rst_flush", {31'd0, flush_out}, 32'd1);
    cp0_rnum = 5'd12;
    #2 rst = 1'b1;
    #1;
    chk("async_flush", {31'd0, flush_out}, 32'd0);
    chk("async_status", cp0_rdata, 32'h0040_0000);
    rd("async_count", 5'd9, 32'd0);
    rd("async_cause", 5'd13, 32'd0);
    reg_wen = 1'b1; reg_num = 5'd5;
    #1;
    chk("async_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("async_redirect", redirect_pc, 32'd0);
    idle();
    step("reset");
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Write-back/commit stage that consumes the registered outputs of the memory stage.
- Drives the register-file write port.
- Arbitrates exceptions and owns the CP0 register set: BadVAddr, Count, Compare, Status, Cause, EPC.
- Issues a single-cycle flush plus redirect PC to the front end on an exception or ERET, and serves CP0 reads to EXE.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions
STATUS_RST, 32'h00400000, Status reset value (BEV=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_in  in  32  PC of instruction in WB
wb_data  in  32  ALU/load result
reg_wen  in  1  GPR write request
reg_num  in  5  GPR destination
cp0_wen  in  1  MTC0 request
cp0_num  in  5  CP0 register number
cp0_sel  in  3  CP0 select
cp0_wdata  in  32  MTC0 data
overflow  in  1  arithmetic overflow
eret  in  1  instruction is ERET
bad_inst  in  1  reserved instruction
bc_inst  in  2  01 syscall, 10 break, 00/11 none
addr_err_read  in  1  load address error
addr_err_write  in  1  store address error
bad_address  in  32  faulting data address
in_delay_slot  in  1  instruction sits in a branch delay slot
hw_int  in  6  external interrupt lines, level
rf_wen  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
cp0_rnum  in  5  CP0 read number (from EXE)
cp0_rsel  in  3  CP0 read select
cp0_rdata  out  32  CP0 read data
flush_out  out  1  flush all earlier stages this cycle
redirect_pc  out  32  next fetch PC when flush_out=1

Behaviour:
- Reset (async, rst=1) sets all CP0 registers as follows; outputs follow combinationally:
  - Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare, tick = 0.
  - rf_wen=0, flush_out=0, redirect_pc=0.
- Register map (sel must be 0, anything else reads 0 and ignores writes):
  - 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
  - Writable Status bits: IM[15:8], EXL[1], IE[0]. Writable Cause bits: IP[9:8]. Other bits read back as stored.
- Interrupt pending: int_req = Status.IE & !Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]).
- Cause.IP[15:10] updates every cycle to {hw_int[5]|TI, hw_int[4:0]}. Cause.TI (bit 30) is sticky.
- Exception priority, highest first, with ExcCode:
  - interrupt 0x00
  - bad_inst 0x0A
  - overflow 0x0C
  - syscall 0x08
  - break 0x09
  - addr_err_read 0x04
  - addr_err_write 0x05
- exc = any of the above.
- On exc:
  - flush_out=1, redirect_pc=EXC_VECTOR, rf_wen=0, and no MTC0 takes effect.
  - Next edge: Cause.ExcCode written and Status.EXL<=1.
  - EPC and Cause.BD are written only if EXL was 0: EPC = in_delay_slot ? pc_in-4 : pc_in; BD = in_delay_slot.
  - BadVAddr<=bad_address only for codes 0x04/0x05.
- On eret with no exc: flush_out=1, redirect_pc=EPC (current value), Status.EXL<=0 next edge.
- Otherwise:
  - rf_wen=reg_wen & (reg_num!=0), rf_waddr=reg_num, rf_wdata=wb_data (combinational; regfile commits on edge).
  - MTC0 commits next edge.
- Count/Compare timer:
  - tick toggles every cycle; Count increments when tick=1 (half clock rate), wrapping at 2^32.
  - Count==Compare (Compare!=0) sets TI.
  - MTC0 Compare clears TI.
  - MTC0 Count in the same cycle as an increment: written value wins.
  - MTC0 Cause/Status in the same cycle as exc: exception update wins.
- cp0_rdata is a combinational read of current register state; MTC0 data is visible the cycle after commit, with no internal bypass.
- Reset asserted mid-instruction clears everything; no partial CP0 write survives.

Decomposition:
- Shared package:
  - ExcCode constants.
  - CP0 register numbers.
  - Status/Cause bit positions.
  - bc_inst encodings.
- One sub-module, cp0_regs: register storage, timer, read mux. The priority arbiter and rf port stay in wb_commit.

Test Plan:
- reg_wen=1, reg_num=5, wb_data=32'h1234 -> rf_wen=1, rf_waddr=5, rf_wdata=32'h1234, flush_out=0; reg_num=0 -> rf_wen=0.
- overflow=1 and bc_inst=01 together, pc_in=32'h80001000, in_delay_slot=1 -> flush_out=1, redirect_pc=32'hBFC00380, rf_wen=0; next cycle EPC=32'h80000FFC, Cause.BD=1, ExcCode=0x0C, EXL=1.
- addr_err_read=1, bad_address=32'h80000003 -> BadVAddr=32'h80000003, ExcCode=0x04; then eret -> redirect_pc=EPC, EXL=0 next cycle.
- Second exception while EXL=1 (bad_inst, pc_in=32'h80002000) -> EPC unchanged, ExcCode=0x0A.
- MTC0 Compare=4, Status=32'h00008001 -> Count reaches 4 after 8 cycles, TI=1, IP7=1, next instruction takes interrupt (ExcCode 0); MTC0 Compare clears TI.
- Assert rst mid-stream after MTC0 Status -> Status=32'h00400000, Count=0, flush_out=0 immediately (async).
